// File: rtl/ternary_run_controller.sv
// ternary_run_controller
//
// Run sequencer for the ternary system: IDLE -> LOADING -> EXECUTING -> HALTED,
// with HALTED -> LOADING on a fresh start. It owns the single memory write
// port and hands it to the loader or the CPU based on the registered state.
// It also decides when the program has finished by watching for a program
// counter that stops moving while the CPU sits in fetch.
//
// Optional feature: define TERNARY_WATCHDOG_EN to build an execution-cycle
// watchdog (limit WATCHDOG_CYCLES). Without it, timeout is tied to 0 and only
// stall detection ends execution.
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   start                 - load-and-run request (honoured in IDLE/HALTED only)
//   load_done             - loader finished (honoured in LOADING only)
//   load_start            - one-cycle pulse on the first LOADING cycle
//   cpu_reset, cpu_enable - CPU hold-in-reset and advance enable
//   pc, cpu_state         - CPU program counter (9 trits) and FSM state (0 = fetch)
//   ldr_mem_*             - loader write request
//   cpu_mem_*             - CPU write request
//   mem_*                 - arbitrated memory write port
//   system_state          - IDLE=0, LOADING=1, EXECUTING=2, HALTED=3
//   cycle_count           - saturating count of EXECUTING cycles
//   timeout               - execution ended by the watchdog

module ternary_run_controller #(
    parameter int unsigned HALT_CYCLES     = 5,
    parameter int unsigned WATCHDOG_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        load_done,
    output logic        load_start,
    output logic        cpu_reset,
    output logic        cpu_enable,
    input  logic [17:0] pc,
    input  logic [2:0]  cpu_state,
    input  logic        ldr_mem_write,
    input  logic [17:0] ldr_mem_addr,
    input  logic [17:0] ldr_mem_wdata,
    input  logic        cpu_mem_write,
    input  logic [17:0] cpu_mem_addr,
    input  logic [17:0] cpu_mem_wdata,
    output logic        mem_write,
    output logic [17:0] mem_addr,
    output logic [17:0] mem_wdata,
    output logic [1:0]  system_state,
    output logic [31:0] cycle_count,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOADING   = 2'd1,
        ST_EXECUTING = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    typedef struct packed {
        logic        write;
        logic [17:0] addr;
        logic [17:0] wdata;
    } mem_req_t;

    // 2'b11 is not a legal trit encoding, so this never matches a real pc.
    localparam logic [17:0] PC_INVALID = 18'h3FFFF;
    localparam logic [3:0]  STALL_LAST = 4'(HALT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [17:0] prev_pc;
    logic [3:0]  stall_cnt;
    logic        stall_cond, stall_hit, wd_hit;
    logic        enter_loading, enter_exec;
    mem_req_t    ldr_req, cpu_req, mem_req;

    // ---------------------------------------------------------------
    // Completion detection
    // ---------------------------------------------------------------
    assign stall_cond = (state == ST_EXECUTING) && (cpu_state == 3'd0) && (pc == prev_pc);
    assign stall_hit  = stall_cond && (stall_cnt == STALL_LAST);

`ifdef TERNARY_WATCHDOG_EN
    logic [32:0] cc_inc;
    logic        timeout_q;

    // 33-bit sum so a saturated counter cannot wrap into a false match.
    assign cc_inc = {1'b0, cycle_count} + 33'd1;
    assign wd_hit = (state == ST_EXECUTING) && (cc_inc == 33'(WATCHDOG_CYCLES));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (enter_loading) begin
            timeout_q <= 1'b0;
        end else if (wd_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    // No watchdog: the limit is still referenced so both builds share one
    // parameter list, but the term folds to constant 0.
    assign wd_hit  = (WATCHDOG_CYCLES == 0) & 1'b0;
    assign timeout = 1'b0;
`endif

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start)                state_nxt = ST_LOADING;
            ST_LOADING:   if (load_done)            state_nxt = ST_EXECUTING;
            ST_EXECUTING: if (stall_hit || wd_hit)  state_nxt = ST_HALTED;
            ST_HALTED:    if (start)                state_nxt = ST_LOADING;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    assign enter_loading = (state_nxt == ST_LOADING)   && (state != ST_LOADING);
    assign enter_exec    = (state_nxt == ST_EXECUTING) && (state != ST_EXECUTING);

    assign system_state = state;
    assign cpu_reset    = (state == ST_IDLE) || (state == ST_LOADING);
    assign cpu_enable   = (state == ST_EXECUTING);

    // Registered so the pulse lines up with the first LOADING cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_start <= 1'b0;
        end else begin
            load_start <= enter_loading;
        end
    end

    // ---------------------------------------------------------------
    // Stall tracking
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_pc   <= PC_INVALID;
            stall_cnt <= 4'd0;
        end else if (enter_exec) begin
            prev_pc   <= PC_INVALID;
            stall_cnt <= 4'd0;
        end else if (state == ST_EXECUTING) begin
            prev_pc   <= pc;
            // Execution leaves at STALL_LAST (<= 14), so this cannot overflow.
            stall_cnt <= stall_cond ? stall_cnt + 4'd1 : 4'd0;
        end
    end

    // ---------------------------------------------------------------
    // Execution cycle counter
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'd0;
        end else if (enter_loading) begin
            cycle_count <= 32'd0;
        end else if ((state == ST_EXECUTING) && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // ---------------------------------------------------------------
    // Memory write port ownership. Selection depends only on the registered
    // state; a request from the non-owner is simply dropped. Because state
    // resets asynchronously, an in-flight write vanishes as soon as reset
    // asserts.
    // ---------------------------------------------------------------
    assign ldr_req = '{write: ldr_mem_write, addr: ldr_mem_addr, wdata: ldr_mem_wdata};
    assign cpu_req = '{write: cpu_mem_write, addr: cpu_mem_addr, wdata: cpu_mem_wdata};

    always_comb begin
        mem_req = '0;
        case (state)
            ST_LOADING:   mem_req = ldr_req;
            ST_EXECUTING: mem_req = cpu_req;
            default:      mem_req = '0;
        endcase
    end

    assign mem_write = mem_req.write;
    assign mem_addr  = mem_req.addr;
    assign mem_wdata = mem_req.wdata;

endmodule

// File: tb/tb_ternary_run_controller.sv
module tb_ternary_run_controller;

    logic        clock;
    logic        reset;
    logic        start, load_done;
    logic        load_start, cpu_reset, cpu_enable;
    logic [17:0] pc;
    logic [2:0]  cpu_state;
    logic        ldr_mem_write, cpu_mem_write, mem_write;
    logic [17:0] ldr_mem_addr, ldr_mem_wdata;
    logic [17:0] cpu_mem_addr, cpu_mem_wdata;
    logic [17:0] mem_addr, mem_wdata;
    logic [1:0]  system_state;
    logic [31:0] cycle_count;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [17:0] addr;
        logic [17:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] cc;
        logic        to;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];
    logic       mon_en = 1'b0;
    logic [1:0] last_state = 2'd0;
    wr_t        we;
    st_t        se;

    ternary_run_controller #(
        .HALT_CYCLES     (5),
        .WATCHDOG_CYCLES (20)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .load_done     (load_done),
        .load_start    (load_start),
        .cpu_reset     (cpu_reset),
        .cpu_enable    (cpu_enable),
        .pc            (pc),
        .cpu_state     (cpu_state),
        .ldr_mem_write (ldr_mem_write),
        .ldr_mem_addr  (ldr_mem_addr),
        .ldr_mem_wdata (ldr_mem_wdata),
        .cpu_mem_write (cpu_mem_write),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_wdata (cpu_mem_wdata),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .system_state  (system_state),
        .cycle_count   (cycle_count),
        .timeout       (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_wr(input logic [17:0] a, input logic [17:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic push_st(input logic [1:0] s, input logic [31:0] c, input logic t);
        st_t e;
        e.st = s;
        e.cc = c;
        e.to = t;
        st_q.push_back(e);
    endtask

    task automatic set_ldr(input logic w, input logic [17:0] a, input logic [17:0] d);
        ldr_mem_write = w;
        ldr_mem_addr  = a;
        ldr_mem_wdata = d;
    endtask

    task automatic set_cpu(input logic w, input logic [17:0] a, input logic [17:0] d);
        cpu_mem_write = w;
        cpu_mem_addr  = a;
        cpu_mem_wdata = d;
    endtask

    // Monitor: every observed memory write and every state change must match
    // the next queued expectation.
    always @(negedge clock) begin
        if (mon_en) begin
            if (mem_write === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_write: got write addr 0x%0h data 0x%0h, expected none",
                             mem_addr, mem_wdata);
                end else begin
                    we = wr_q.pop_front();
                    chk("sb_mem_addr", 32'(mem_addr), 32'(we.addr));
                    chk("sb_mem_wdata", 32'(mem_wdata), 32'(we.data));
                end
            end
            if (system_state !== last_state) begin
                if (st_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_state: got transition to %0d, expected none", system_state);
                end else begin
                    se = st_q.pop_front();
                    chk("sb_state", 32'(system_state), 32'(se.st));
                    chk("sb_cycle_count", cycle_count, se.cc);
                    chk("sb_timeout", 32'(timeout), 32'(se.to));
                end
                last_state = system_state;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; load_done = 1'b0;
        pc = 18'd0; cpu_state = 3'd0;
        set_ldr(1'b0, 18'd0, 18'd0);
        set_cpu(1'b0, 18'd0, 18'd0);
        #1 reset = 1'b0;
        #1;
        chk("rst_state", 32'(system_state), 32'd0);
        chk("rst_load_start", 32'(load_start), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_enable", 32'(cpu_enable), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_stall_cnt", 32'(u_dut.stall_cnt), 32'd0);
        chk("rst_prev_pc", 32'(u_dut.prev_pc), 32'h3FFFF);
        // Both requesters active while idle: nothing reaches memory.
        set_ldr(1'b1, 18'h1, 18'h2);
        set_cpu(1'b1, 18'h3, 18'h4);
        #1;
        chk("idle_mem_write", 32'(mem_write), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);
        #1 reset = 1'b1;
        mon_en = 1'b1;
        tick();
        chk("idle_hold", 32'(system_state), 32'd0);
        set_ldr(1'b0, 18'd0, 18'd0);
        set_cpu(1'b0, 18'd0, 18'd0);

        // Start -> LOADING, loader owns the port.
        start = 1'b1;
        push_st(2'd1, 32'd0, 1'b0);
        tick();
        start = 1'b0;
        chk("load_state", 32'(system_state), 32'd1);
        chk("load_start_pulse", 32'(load_start), 32'd1);
        chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("load_cpu_enable", 32'(cpu_enable), 32'd0);
        set_ldr(1'b1, 18'h5, 18'h15);
        set_cpu(1'b1, 18'h9, 18'h2A);
        push_wr(18'h5, 18'h15);
        tick();
        set_ldr(1'b0, 18'd0, 18'd0);
        set_cpu(1'b0, 18'd0, 18'd0);
        chk("load_start_single", 32'(load_start), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_loading", 32'(system_state), 32'd1);

        // LOADING -> EXECUTING, CPU owns the port.
        load_done = 1'b1;
        push_st(2'd2, 32'd0, 1'b0);
        tick();
        load_done = 1'b0;
        chk("exec_state", 32'(system_state), 32'd2);
        chk("exec_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("exec_cpu_enable", 32'(cpu_enable), 32'd1);
        pc = 18'd0; cpu_state = 3'd0;
        set_cpu(1'b1, 18'h7, 18'h33);
        set_ldr(1'b1, 18'h1, 18'h11);
        push_wr(18'h7, 18'h33);
        tick();
        set_cpu(1'b0, 18'd0, 18'd0);
        set_ldr(1'b0, 18'd0, 18'd0);
        pc = 18'd1; tick();
        pc = 18'd2; tick();
        pc = 18'd3; tick();
        tick(); tick(); tick(); tick();
        chk("stall_not_early", 32'(system_state), 32'd2);
        push_st(2'd3, 32'd9, 1'b0);
        tick();
        chk("stall_halt", 32'(system_state), 32'd3);
        chk("stall_cycle_count", cycle_count, 32'd9);
        set_ldr(1'b1, 18'h2, 18'h2);
        set_cpu(1'b1, 18'h3, 18'h3);
        tick(); tick();
        set_ldr(1'b0, 18'd0, 18'd0);
        set_cpu(1'b0, 18'd0, 18'd0);
        chk("halt_cc_frozen", cycle_count, 32'd9);
        chk("halt_cpu_enable", 32'(cpu_enable), 32'd0);
        chk("halt_cpu_reset", 32'(cpu_reset), 32'd0);

        // Zero-length program, then pc held with cpu_state alternating.
        start = 1'b1;
        push_st(2'd1, 32'd0, 1'b0);
        tick();
        start = 1'b0;
        load_done = 1'b1;
        chk("zl_load_start", 32'(load_start), 32'd1);
        push_st(2'd2, 32'd0, 1'b0);
        tick();
        load_done = 1'b0;
        chk("zl_exec", 32'(system_state), 32'd2);
        pc = 18'd3;
        for (int i = 0; i < 20; i++) begin
            cpu_state = (i % 2 == 1) ? 3'd2 : 3'd0;
            tick();
            chk("alt_no_halt", 32'(system_state), 32'd2);
            chk("alt_stall_le1", 32'(u_dut.stall_cnt <= 4'd1), 32'd1);
        end
        chk("alt_cycle_count", cycle_count, 32'd20);
        cpu_state = 3'd0;
        tick(); tick(); tick(); tick();
        chk("alt_stall_not_early", 32'(system_state), 32'd2);
        push_st(2'd3, 32'd25, 1'b0);
        tick();
        chk("alt_halt", 32'(system_state), 32'd3);

        // Watchdog (or its absence) with a pc that always moves.
        start = 1'b1;
        push_st(2'd1, 32'd0, 1'b0);
        tick();
        start = 1'b0;
        load_done = 1'b1;
        push_st(2'd2, 32'd0, 1'b0);
        tick();
        load_done = 1'b0;
`ifdef TERNARY_WATCHDOG_EN
        for (int i = 0; i < 19; i++) begin
            pc = 18'(i);
            tick();
        end
        chk("wd_not_early", 32'(system_state), 32'd2);
        chk("wd_cc_19", cycle_count, 32'd19);
        pc = 18'd19;
        push_st(2'd3, 32'd20, 1'b1);
        tick();
        chk("wd_halt", 32'(system_state), 32'd3);
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_cycle_count", cycle_count, 32'd20);
        start = 1'b1;
        push_st(2'd1, 32'd0, 1'b0);
        tick();
        start = 1'b0;
        chk("wd_reload_timeout", 32'(timeout), 32'd0);
        chk("wd_reload_cc", cycle_count, 32'd0);
        load_done = 1'b1;
        push_st(2'd2, 32'd0, 1'b0);
        tick();
        load_done = 1'b0;
        pc = 18'd0;
        tick(); tick(); tick(); tick(); tick();
        push_st(2'd3, 32'd6, 1'b0);
        tick();
        chk("wd_stall_halt", 32'(system_state), 32'd3);
`else
        for (int i = 0; i < 30; i++) begin
            pc = 18'(i);
            tick();
        end
        chk("nowd_state", 32'(system_state), 32'd2);
        chk("nowd_timeout", 32'(timeout), 32'd0);
        chk("nowd_cycle_count", cycle_count, 32'd30);
        tick(); tick(); tick(); tick();
        push_st(2'd3, 32'd35, 1'b0);
        tick();
        chk("nowd_stall_halt", 32'(system_state), 32'd3);
`endif

        // start held high: ignored while executing, re-triggers from HALTED.
        start = 1'b1;
        push_st(2'd1, 32'd0, 1'b0);
        tick();
        load_done = 1'b1;
        push_st(2'd2, 32'd0, 1'b0);
        tick();
        load_done = 1'b0;
        chk("held_start_exec", 32'(system_state), 32'd2);
        pc = 18'd0; cpu_state = 3'd0;
        tick(); tick(); tick(); tick(); tick();
        chk("held_start_no_reload", 32'(system_state), 32'd2);
        push_st(2'd3, 32'd6, 1'b0);
        tick();
        chk("held_start_halt", 32'(system_state), 32'd3);
        push_st(2'd1, 32'd0, 1'b0);
        tick();
        start = 1'b0;
        chk("held_start_reload", 32'(system_state), 32'd1);
        chk("held_start_pulse", 32'(load_start), 32'd1);

        // Reset mid-EXECUTING with a CPU write in flight.
        load_done = 1'b1;
        push_st(2'd2, 32'd0, 1'b0);
        tick();
        load_done = 1'b0;
        pc = 18'd5; cpu_state = 3'd1;
        tick();
        pc = 18'd6;
        tick();
        pc = 18'd7;
        set_cpu(1'b1, 18'h12, 18'h34);
        #1;
        chk("inflight_mem_write", 32'(mem_write), 32'd1);
        chk("inflight_mem_addr", 32'(mem_addr), 32'h12);
        chk("inflight_cc", cycle_count, 32'd2);
        push_st(2'd0, 32'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("async_mem_write", 32'(mem_write), 32'd0);
        chk("async_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_state", 32'(system_state), 32'd0);
        chk("async_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("async_cycle_count", cycle_count, 32'd0);
        set_cpu(1'b0, 18'd0, 18'd0);
        #1 reset = 1'b1;
        tick(); tick();
        chk("post_reset_idle", 32'(system_state), 32'd0);
        chk("sb_wr_drained", 32'(wr_q.size()), 32'd0);
        chk("sb_st_drained", 32'(st_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
